// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for a 5-stage pipe with mul/div wait and CSR drain FSM; outputs are combinational, counters registered.
// PERF_CNT_EN adds free-running stall_cycles/flush_events counters; without it neither port nor register exists.
module pipe_ctrl #(
   parameter int NSTAGE     = 4,
   parameter int MD_STAGE   = 3,
   parameter int BR_STAGE   = 3,
   parameter int MD_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_wait,
   input  logic              dmem_wait,
   input  logic              load_use,
   input  logic              redirect,
   input  logic              md_start,
   input  logic              md_done,
   input  logic              csr_req,
   input  logic              trap_req,
   input  logic [NSTAGE:0]   stage_valid,
   output logic [NSTAGE:0]   stall,
   output logic [NSTAGE:0]   flush,
   output logic              csr_go,
   output logic              md_kill,
   output logic              md_timeout,
   output logic [1:0]        state
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
`endif
);

   localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN = 2'd0, MDWAIT = 2'd1, DRAIN = 2'd2} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [NSTAGE:0] w_src;
   logic [NSTAGE:0] w_therm;
   logic            w_drained;
   logic            w_unused;

   assign w_drained = (stage_valid[NSTAGE:3] == '0);
   assign w_unused  = ^stage_valid[2:0];
   assign state     = reset ? RUN : r_state;

   // w_src marks the stage each active hazard holds; w_therm[i] = some source at or above i.
   always_comb begin
      logic w_acc;
      w_src = '0;
      w_src[NSTAGE]   = dmem_wait;
      w_src[MD_STAGE] = w_src[MD_STAGE] | ((r_state == MDWAIT) & ~md_done);
      w_src[2]        = w_src[2] | ((r_state == DRAIN) & ~w_drained) | load_use;
      w_src[1]        = w_src[1] | imem_wait;
      w_acc   = 1'b0;
      w_therm = '0;
      for (int i = NSTAGE; i >= 0; i--) begin
         w_acc      = w_acc | w_src[i];
         w_therm[i] = w_acc;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      stall      = w_therm;
      flush      = '0;
      csr_go     = 1'b0;
      md_kill    = 1'b0;
      md_timeout = 1'b0;
      for (int i = 1; i <= NSTAGE; i++) begin
         flush[i] = w_therm[i-1] & ~w_therm[i];
      end

      if (redirect && !w_therm[BR_STAGE]) begin
         for (int i = 1; i < BR_STAGE; i++) begin
            flush[i] = 1'b1;
            stall[i] = 1'b0;
         end
      end

      case (r_state)
         RUN: begin
            if (csr_req && !w_therm[2] && !redirect) begin
               w_next = DRAIN;
            end else if (md_start && !w_therm[MD_STAGE]) begin
               w_next     = MDWAIT;
               w_cnt_next = '0;
            end
         end
         MDWAIT: begin
            if (md_done) begin
               w_next = RUN;
            end else if (r_cnt == CNT_LAST) begin
               md_timeout = 1'b1;
               md_kill    = 1'b1;
               w_next     = RUN;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         DRAIN: begin
            if (w_drained) begin
               csr_go = 1'b1;
               w_next = RUN;
            end
         end
         default: w_next = RUN;
      endcase

      // Trap squashes everything younger than the PC and aborts any mul/div in flight.
      if (trap_req) begin
         stall      = '0;
         flush      = {{NSTAGE{1'b1}}, 1'b0};
         csr_go     = 1'b0;
         md_timeout = 1'b0;
         md_kill    = (r_state == MDWAIT);
         w_next     = RUN;
      end

      if (reset) begin
         stall      = '0;
         flush      = '1;
         csr_go     = 1'b0;
         md_kill    = 1'b0;
         md_timeout = 1'b0;
         w_next     = RUN;
         w_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (|flush)   r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NSTAGE=4, MD_TIMEOUT=8): expected outputs queued per step, popped and checked at the negedge.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       imem_wait, dmem_wait, load_use, redirect;
   logic       md_start, md_done, csr_req, trap_req;
   logic [4:0] stage_valid;
   logic [4:0] stall, flush;
   logic       csr_go, md_kill, md_timeout;
   logic [1:0] state;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
   logic [31:0] fe0, sc0;
`endif

   int total = 0;
   int bad   = 0;

   typedef logic [14:0] exp_t;  // {stall, flush, csr_go, md_kill, md_timeout, state}
   exp_t  q_exp[$];
   string q_tag[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.NSTAGE(4), .MD_STAGE(3), .BR_STAGE(3), .MD_TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_wait   (imem_wait),
      .dmem_wait   (dmem_wait),
      .load_use    (load_use),
      .redirect    (redirect),
      .md_start    (md_start),
      .md_done     (md_done),
      .csr_req     (csr_req),
      .trap_req    (trap_req),
      .stage_valid (stage_valid),
      .stall       (stall),
      .flush       (flush),
      .csr_go      (csr_go),
      .md_kill     (md_kill),
      .md_timeout  (md_timeout),
      .state       (state)
`ifdef PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_events(flush_events)
`endif
   );

   function automatic exp_t mk(logic [4:0] s, logic [4:0] f, logic g, logic k, logic t, logic [1:0] st);
      return {s, f, g, k, t, st};
   endfunction

   task automatic idle();
      imem_wait = 0; dmem_wait = 0; load_use = 0; redirect = 0;
      md_start = 0; md_done = 0; csr_req = 0; trap_req = 0;
      stage_valid = 5'b00000;
   endtask

   // Inputs are already driven; queue the expectation, sample at negedge, then advance to posedge+1.
   task automatic cyc(string tag, exp_t e);
      exp_t  obs;
      exp_t  x;
      string t;
      q_exp.push_back(e);
      q_tag.push_back(tag);
      @(negedge clk);
      obs = {stall, flush, csr_go, md_kill, md_timeout, state};
      x = q_exp.pop_front();
      t = q_tag.pop_front();
      total++;
      assert (obs === x) else begin
         bad++;
         $error("FAIL %s observed stall=%b flush=%b go=%b kill=%b tmo=%b st=%0d expected stall=%b flush=%b go=%b kill=%b tmo=%b st=%0d",
                t, obs[14:10], obs[9:5], obs[4], obs[3], obs[2], obs[1:0],
                x[14:10], x[9:5], x[4], x[3], x[2], x[1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1; load_use = 1; md_start = 1;
      cyc("reset0", mk(5'b00000, 5'b11111, 0, 0, 0, 2'd0));
      cyc("reset1", mk(5'b00000, 5'b11111, 0, 0, 0, 2'd0));
      reset = 0; idle();
      cyc("idle", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      load_use = 1;
      cyc("load_use", mk(5'b00111, 5'b01000, 0, 0, 0, 2'd0));
      idle();
      cyc("load_use_after", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      imem_wait = 1;
      cyc("imem_wait", mk(5'b00011, 5'b00100, 0, 0, 0, 2'd0));
      idle(); dmem_wait = 1;
      cyc("dmem_wait", mk(5'b11111, 5'b00000, 0, 0, 0, 2'd0));

      redirect = 1;
      cyc("redir_dmem", mk(5'b11111, 5'b00000, 0, 0, 0, 2'd0));
      dmem_wait = 0;
      cyc("redir_applied", mk(5'b00000, 5'b00110, 0, 0, 0, 2'd0));
      load_use = 1;
      cyc("redir_load_use", mk(5'b00001, 5'b01110, 0, 0, 0, 2'd0));
      idle();

      md_start = 1;
      cyc("md_start", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      md_start = 0;
      for (int i = 1; i <= 4; i++)
         cyc($sformatf("mdwait%0d", i), mk(5'b01111, 5'b10000, 0, 0, 0, 2'd1));
      md_done = 1;
      cyc("md_done", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd1));
      md_done = 0;
      cyc("md_back_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      md_start = 1; dmem_wait = 1;
      cyc("md_start_blocked", mk(5'b11111, 5'b00000, 0, 0, 0, 2'd0));
      idle();
      cyc("md_blocked_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      md_start = 1;
      cyc("tmo_start", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      md_start = 0;
      for (int i = 1; i <= 7; i++)
         cyc($sformatf("tmo_wait%0d", i), mk(5'b01111, 5'b10000, 0, 0, 0, 2'd1));
      cyc("tmo_pulse", mk(5'b01111, 5'b10000, 0, 1, 1, 2'd1));
      cyc("tmo_back_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      csr_req = 1; stage_valid = 5'b11000;
      cyc("csr_req", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      csr_req = 0;
      cyc("drain_a", mk(5'b00111, 5'b01000, 0, 0, 0, 2'd2));
      stage_valid = 5'b01000;
      cyc("drain_b", mk(5'b00111, 5'b01000, 0, 0, 0, 2'd2));
      stage_valid = 5'b00000;
      cyc("csr_go", mk(5'b00000, 5'b00000, 1, 0, 0, 2'd2));
      cyc("csr_back_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      csr_req = 1; md_start = 1;
      cyc("csr_prio", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      idle();
      cyc("csr_prio_go", mk(5'b00000, 5'b00000, 1, 0, 0, 2'd2));
      redirect = 1; csr_req = 1;
      cyc("csr_redir", mk(5'b00000, 5'b00110, 0, 0, 0, 2'd0));
      idle();
      cyc("csr_redir_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      md_start = 1;
      cyc("trap_md_start", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      md_start = 0;
      cyc("trap_mdwait", mk(5'b01111, 5'b10000, 0, 0, 0, 2'd1));
      trap_req = 1; load_use = 1;
`ifdef PERF_CNT_EN
      fe0 = flush_events; sc0 = stall_cycles;
`endif
      cyc("trap_md", mk(5'b00000, 5'b11110, 0, 1, 0, 2'd1));
      idle();
`ifdef PERF_CNT_EN
      total++;
      assert (flush_events === fe0 + 32'd1) else begin
         bad++;
         $error("FAIL perf_flush observed=%0d expected=%0d", flush_events, fe0 + 32'd1);
      end
      total++;
      assert (stall_cycles === sc0) else begin
         bad++;
         $error("FAIL perf_stall observed=%0d expected=%0d", stall_cycles, sc0);
      end
`endif
      cyc("trap_back_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      trap_req = 1;
      cyc("trap_run", mk(5'b00000, 5'b11110, 0, 0, 0, 2'd0));
      idle();

      md_start = 1;
      cyc("rst_md_start", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      md_start = 0; reset = 1;
      cyc("rst_mid_md", mk(5'b00000, 5'b11111, 0, 0, 0, 2'd0));
      reset = 0;
      cyc("rst_md_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      csr_req = 1;
      cyc("rst_csr_req", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));
      csr_req = 0; reset = 1;
      cyc("rst_mid_drain", mk(5'b00000, 5'b11111, 0, 0, 0, 2'd0));
      reset = 0;
      cyc("rst_drain_run", mk(5'b00000, 5'b00000, 0, 0, 0, 2'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, 4, index of last pipeline register; stage 0 = PC, 1 = F, 2 = D, 3 = E, 4 = M.
REQ-002 SHALL have parameter MD_STAGE, 3, stage holding a multi-cycle (mul/div) op.
REQ-003 SHALL have parameter BR_STAGE, 3, stage resolving redirects.
REQ-004 SHALL have parameter MD_TIMEOUT, 64, maximum MDWAIT cycles before abort.
REQ-005 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-006 SHALL have ports: imem_wait input 1, fetch not ready; dmem_wait input 1, data memory not ready; load_use input 1, load-use hazard in D.
REQ-007 SHALL have ports: redirect input 1, taken branch/jump in BR_STAGE; md_start input 1, mul/div entering MDWAIT; md_done input 1, mul/div result ready.
REQ-008 SHALL have ports: csr_req input 1, CSR/fence in D needing serialisation; trap_req input 1, exception/interrupt; stage_valid input NSTAGE+1, per-stage valid (bit 0 ignored).
REQ-009 SHALL have ports: stall output NSTAGE+1, hold stage i; flush output NSTAGE+1, load bubble into stage i; csr_go output 1, CSR may execute; md_kill output 1, abort mul/div; md_timeout output 1, error pulse; state output 2, FSM state.
REQ-010 SHALL have ports, present only under PERF_CNT_EN: stall_cycles output 32, flush_events output 32.

Function
REQ-011 SHALL run FSM RUN=0, MDWAIT=1, DRAIN=2; all outputs combinational from state and inputs, except counters.
REQ-012 SHALL form the stall vector as a thermometer: stall[0..h] = 1, where h = highest active source stage; stall[h+1] gets flush = 1 if h < NSTAGE.
REQ-013 SHALL use these sources: dmem_wait h = NSTAGE, no bubble; MDWAIT h = MD_STAGE; DRAIN h = 2; load_use h = 2; imem_wait h = 1.
REQ-014 SHALL, on redirect with h < BR_STAGE, set flush[1..BR_STAGE-1] = 1, overriding the stall bits of those stages.
REQ-015 SHALL ignore redirect when h >= BR_STAGE; the source holds redirect until applied.
REQ-016 SHALL, when trap_req is high in any state, set flush[1..NSTAGE] = 1 and stall = 0, override all other sources, next state RUN, and assert md_kill if the state is MDWAIT.
REQ-017 SHALL move RUN to MDWAIT on md_start when h < MD_STAGE; the timeout counter clears to 0.
REQ-018 SHALL move MDWAIT to RUN on the cycle after md_done = 1; md_done in that cycle already releases stall.
REQ-019 SHALL, when the MDWAIT counter reaches MD_TIMEOUT-1 without md_done, pulse md_timeout and md_kill for 1 cycle, then return to RUN.
REQ-020 SHALL move RUN to DRAIN on csr_req when h < 2 and no redirect; csr_req has priority over md_start.
REQ-021 SHALL hold DRAIN until stage_valid[NSTAGE:3] == 0, then pulse csr_go for 1 cycle, return to RUN, and release stall that same cycle.
REQ-022 SHALL count the timeout counter to ceil(log2(MD_TIMEOUT)) bits with no wrap; it saturates at the abort.

Reset
REQ-023 SHALL, while reset = 1, drive state = RUN, stall = 0, flush = all ones, csr_go = md_kill = md_timeout = 0, and clear the timeout counter.
REQ-024 SHALL, on reset asserted mid-MDWAIT or mid-DRAIN, abandon the state with no csr_go or md_kill pulse.

Configuration
REQ-025 SHALL, with PERF_CNT_EN defined, increment stall_cycles each cycle stall[0] = 1 and flush_events each cycle any flush bit = 1, both wrapping at 2^32, reset to 0, and held during reset.
REQ-026 SHALL, without PERF_CNT_EN, omit both counter ports and their registers.

Verification
REQ-027 SHALL cover: load_use=1 for 1 cycle, NSTAGE=4 -> stall=5'b00111, flush=5'b01000; next cycle stall=0, flush=0.
REQ-028 SHALL cover: md_start, md_done 5 cycles later -> state=1 for 5 cycles with stall=5'b01111, flush[4]=1; state=0 on the 6th cycle.
REQ-029 SHALL cover: md_start, no md_done, MD_TIMEOUT=8 -> md_timeout and md_kill pulse on the 8th MDWAIT cycle; state=0 next.
REQ-030 SHALL cover: csr_req with stage_valid=5'b11000 clearing over 2 cycles -> state=2, stall=5'b00111; csr_go pulses once when stage_valid[4:3]=0.
REQ-031 SHALL cover: redirect together with dmem_wait -> flush=0, stall=5'b11111; after dmem_wait drops with redirect held, flush=5'b00110.
REQ-032 SHALL cover: trap_req during MDWAIT -> flush=5'b11110, stall=0, md_kill=1, state=0 next cycle; with PERF_CNT_EN, flush_events increments by 1.
